rr_mux_sel_arbiter: RTL and testbench
=====================================

// Module: rr_mux_sel_arbiter
// PURPOSE
//   Round-robin arbiter that sits directly upstream of the 4:1 data mux (fourx1mux).
//   It arbitrates among four requesting sources and drives the mux select sel[1:0].
//   A granted source holds the mux for a fixed burst of BURST_LEN beats.
//   Beats are handshaked with the downstream consumer via valid/ready.
// PARAMETERS
//   BURST_LEN   4   beats per grant; legal range 1..255
//   CNT_W       8   width of the beat counter; must satisfy 2**CNT_W > BURST_LEN-1
// PORTS
//   clk    in   1  single clock; all state updates on posedge
//   rst    in   1  synchronous, active-high reset
//   req    in   4  per-source request; bit i = source i (mux input a,b,c,d = 0..3)
//   ready  in   1  downstream accepts the current beat
//   sel    out  2  mux select, index of the granted source
//   grant  out  4  one-hot grant; 4'b0000 when idle
//   valid  out  1  a beat from the granted source is presented
//   last   out  1  valid beat is the final beat of the burst
// BEHAVIOUR
//   Reset values (rst=1 sampled at posedge):
//     state=IDLE, sel=2'b00, grant=4'b0000, valid=0, last=0, cnt=0, ptr=2'd3.
//   Pointer:
//     ptr = last granted index.
//     Search order is ptr+1, ptr+2, ptr+3, ptr, all mod 4, so the first grant after reset goes to source 0.
//   States:
//     IDLE: if req!=0, the winner is picked in this cycle.
//       Next cycle: state=BUSY, sel=idx, grant=1<<idx, valid=1, cnt=0, ptr=idx.
//       If req==0, stay in IDLE.
//     BUSY: valid=1 throughout.
//       A beat completes when valid&&ready; on each completed beat cnt increments.
//       last = valid && (cnt==BURST_LEN-1), combinational from registered cnt.
//       If ready=0, sel, grant and cnt hold unchanged (stall of any length).
//       Final beat accepted, req!=0: re-arbitrate the same cycle (current req, current ptr).
//         Next cycle is the new grant with cnt=0, so there are no idle cycles between bursts.
//       Final beat accepted, req==0: go to IDLE; valid=0 and grant=0 next cycle.
//       sel keeps its last value in IDLE.
//   Grant latency: 1 cycle from req sampled in IDLE to valid=1.
//   Boundary rules:
//     Granted source drops req mid-burst: the burst still runs to BURST_LEN beats.
//     The same source may win back-to-back only if no other source requests.
//     BURST_LEN=1: last=1 on every valid beat.
//     cnt never exceeds BURST_LEN-1; ptr wraps 3->0.
//     rst mid-burst: reset values on the next edge; the burst is abandoned with no last.
//   Invariants: grant is one-hot or zero; grant==0 iff valid==0; sel==index(grant) whenever valid.
// STRUCTURE
//   Shared package mux_pkg:
//     state encodings IDLE=1'b0, BUSY=1'b1
//     NUM_SRC=4, SEL_W=2
//   One combinational sub-module rr_pick4:
//     inputs req[3:0], ptr[1:0]
//     outputs any, idx[1:0]
//   Top-level holds the FSM, the counter and the registered outputs.
//   sel feeds the mux sel port directly.
// TESTING
//   1. rst=1 for 2 cycles with req=4'b1111
//      -> sel=0, grant=0, valid=0, last=0.
//   2. req=4'b1111, ready=1 continuous, BURST_LEN=4
//      -> grants 0,1,2,3,0 with 4 beats each, no gaps.
//      -> last is high on every 4th beat.
//   3. req=4'b0100 for 1 cycle only, ready=1
//      -> grant=4'b0100, sel=2 for 4 beats, then IDLE and valid=0.
//   4. Source 1 granted, ready=0 for 5 cycles mid-burst
//      -> sel, cnt and grant frozen; the burst finishes after 4 accepted beats.
//   5. rst asserted after beat 2 of a burst
//      -> reset values next cycle; with req=4'b0001 the next grant is source 0.
//   6. req=4'b1000 alone repeatedly
//      -> source 3 is re-granted back-to-back with no idle cycle.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pkg
//  Purpose  : Shared constants, types and helpers for the 4:1 mux select
//             arbiter and its round-robin picker.
//  Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Number of sources feeding the downstream 4:1 mux and select width
    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;

    // Arbiter FSM state encodings
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [NUM_SRC-1:0] req_t;

    // One-hot vector with only bit 'idx' set
    function automatic req_t onehot(input sel_t idx);
        return req_t'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick4
//  Purpose  : Combinational round-robin picker for four requesters. Searches
//             ptr+1, ptr+2, ptr+3, ptr (mod 4) and reports the first hit.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick4
    import mux_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk the search order from the lowest priority upward so the highest
    // priority hit (smallest offset past ptr) is the last one assigned.
    always_comb begin
        any    = 1'b0;
        idx    = ptr;
        w_cand = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            // Offset 4 wraps to ptr itself, giving it the lowest priority
            w_cand = ptr + SEL_W'(k);
            if (req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux_sel_arbiter
//  Purpose  : Round-robin arbiter driving the select of a downstream 4:1 data
//             mux. A winner holds the mux for BURST_LEN beats, each beat
//             handshaked with valid/ready. Back-to-back bursts carry no gap.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_mux_sel_arbiter
    import mux_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 8
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               ready,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_SRC-1:0] grant,
    output logic               valid,
    output logic               last
);

    // Count value of the final beat in a burst
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(BURST_LEN - 1);

    // Registered state
    logic [0:0]         r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_SRC-1:0] r_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [SEL_W-1:0]   r_ptr;

    // Next-state values
    logic [0:0]         w_state_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [NUM_SRC-1:0] w_grant_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SEL_W-1:0]   w_ptr_nxt;

    // Picker results and handshake qualifiers
    logic               w_any;
    logic [SEL_W-1:0]   w_idx;
    logic               w_beat;
    logic               w_cnt_last;
    logic               w_load;

    // Round-robin winner among the current requests, relative to last grant
    rr_pick4 u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    assign w_beat     = (r_state == BUSY) && ready;
    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_ptr   <= SEL_W'(NUM_SRC - 1);
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state: start a burst from IDLE, count accepted beats in BUSY, and
    // re-arbitrate on the final beat so consecutive bursts abut.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_load      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_load = 1'b1;
                end
            end
            BUSY: begin
                if (w_beat) begin
                    if (w_cnt_last) begin
                        if (w_any) begin
                            w_load = 1'b1;
                        end else begin
                            // sel keeps its last value while idle
                            w_state_nxt = IDLE;
                            w_grant_nxt = '0;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase

        // New grant: the winner takes the mux and becomes the new pointer
        if (w_load) begin
            w_state_nxt = BUSY;
            w_sel_nxt   = w_idx;
            w_grant_nxt = onehot(w_idx);
            w_cnt_nxt   = '0;
            w_ptr_nxt   = w_idx;
        end
    end

    // Outputs decoded from registered state; last flags the final beat
    always_comb begin
        valid = (r_state == BUSY);
        last  = (r_state == BUSY) && w_cnt_last;
        sel   = r_sel;
        grant = r_grant;
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_mux_sel_arbiter
//  Purpose  : Directed, scoreboard-checked bench for rr_mux_sel_arbiter.
//             Stimulus pushes the expected accepted beats; a monitor pops and
//             compares on every valid&&ready cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_sel_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       last;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] grant;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    rr_mux_sel_arbiter #(
        .BURST_LEN (4),
        .CNT_W     (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ready (ready),
        .sel   (sel),
        .grant (grant),
        .valid (valid),
        .last  (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue nbeats expected accepted beats from source s; last on the 4th
    task automatic push_burst(input int s, input int nbeats, input bit ends);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.sel   = 2'(s);
            b.grant = 4'b0001 << s;
            b.last  = ends && (i == 3);
            exp_q.push_back(b);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: check each accepted beat against the scoreboard plus invariants
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (!((grant == 4'b0000 && !valid) ||
                  (valid && grant == (4'b0001 << sel)))) begin
                bad++;
                $display("FAIL invariant: grant=%b valid=%b sel=%0d at %0t", grant, valid, sel, $time);
            end
            if (valid && ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat: unexpected sel=%0d grant=%b last=%b at %0t", sel, grant, last, $time);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (sel !== e.sel || grant !== e.grant || last !== e.last) begin
                        bad++;
                        $display("FAIL beat: got sel=%0d grant=%b last=%b expected sel=%0d grant=%b last=%b at %0t",
                                 sel, grant, last, e.sel, e.grant, e.last, $time);
                    end
                end
            end
        end
    end

    initial begin
        // 1. reset with all requests pending
        rst   = 1'b1;
        req   = 4'b1111;
        ready = 1'b1;
        tick(2);
        chk("rst_sel",   32'(sel),   32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_last",  32'(last),  32'd0);

        // 2. continuous requests: sources 0,1,2,3,0 with no gaps
        push_burst(0, 4, 1'b1);
        push_burst(1, 4, 1'b1);
        push_burst(2, 4, 1'b1);
        push_burst(3, 4, 1'b1);
        push_burst(0, 4, 1'b1);
        rst = 1'b0;
        tick(1);
        for (int i = 0; i < 20; i++) begin
            chk("rr_nogap", 32'(valid), 32'd1);
            if (i == 19) req = 4'b0000;
            tick(1);
        end
        chk("rr_idle", 32'(valid), 32'd0);
        chk("rr_idle_grant", 32'(grant), 32'd0);

        // 3. single-cycle request from source 2
        push_burst(2, 4, 1'b1);
        req = 4'b0100;
        tick(1);
        req = 4'b0000;
        chk("one_sel", 32'(sel), 32'd2);
        tick(4);
        chk("one_idle", 32'(valid), 32'd0);
        chk("idle_sel_hold", 32'(sel), 32'd2);

        // 4. source 1 burst with a 5-cycle stall after the first beat
        push_burst(1, 4, 1'b1);
        req = 4'b0010;
        tick(1);
        req = 4'b0000;
        tick(1);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_sel",   32'(sel),   32'd1);
            chk("stall_grant", 32'(grant), 32'b0010);
            chk("stall_last",  32'(last),  32'd0);
            tick(1);
        end
        ready = 1'b1;
        tick(3);
        chk("stall_done", 32'(valid), 32'd0);

        // 5. reset after two beats of a source 1 burst, then full requests
        push_burst(1, 2, 1'b0);
        req = 4'b0010;
        tick(1);
        req = 4'b0000;
        tick(2);
        rst   = 1'b1;
        ready = 1'b0;
        tick(1);
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_grant", 32'(grant), 32'd0);
        chk("mrst_sel",   32'(sel),   32'd0);
        chk("mrst_last",  32'(last),  32'd0);
        rst   = 1'b0;
        ready = 1'b1;
        push_burst(0, 4, 1'b1);
        req = 4'b1111;
        tick(1);
        req = 4'b0000;
        chk("mrst_regrant", 32'(grant), 32'b0001);
        tick(4);
        chk("mrst_done", 32'(valid), 32'd0);

        // 6. lone source 3 re-granted back-to-back
        push_burst(3, 4, 1'b1);
        push_burst(3, 4, 1'b1);
        push_burst(3, 4, 1'b1);
        req = 4'b1000;
        tick(1);
        for (int i = 0; i < 12; i++) begin
            chk("b2b_nogap", 32'(valid), 32'd1);
            if (i == 11) req = 4'b0000;
            tick(1);
        end
        chk("b2b_idle", 32'(valid), 32'd0);

        tick(2);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
